// File: rtl/mmio_master.sv
// mmio_master: single-outstanding MMIO bus initiator.
// A command is taken on a valid/ready channel, exactly one read or write cycle
// is run on the MMIO bus, and the result comes back on a valid/ready channel.
// Optional feature macro: MMIO_POLL_EN. When it is defined, op 10 repeatedly
// reads an address until a masked compare matches or POLL_MAX reads have
// missed. When it is undefined, op 10 is handled as a reserved op.
// All outputs are registered. Bus fields are loaded on the command-accept edge,
// so the first bus cycle lines up with the ACCESS state.
module mmio_master #(
  parameter int unsigned RD_LATENCY = 1,
  parameter logic [31:0] IDLE_ADDR  = 32'hFFFF_FFFC,
  parameter logic [15:0] POLL_MAX   = 16'd1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_i_valid,
  output logic        cmd_o_ready,
  input  logic [1:0]  cmd_i_op,
  input  logic [31:0] cmd_i_addr,
  input  logic [31:0] cmd_i_wdata,
  input  logic [3:0]  cmd_i_wmask,
  input  logic [31:0] cmd_i_mask,
  output logic        rsp_o_valid,
  input  logic        rsp_i_ready,
  output logic [31:0] rsp_o_rdata,
  output logic        rsp_o_err,
  output logic [31:0] mmio_o_addr,
  output logic [3:0]  mmio_o_wmask,
  output logic [31:0] mmio_o_wdata,
  input  logic [31:0] mmio_i_rdata,
  output logic        busy
);

  localparam logic [1:0] OP_RD   = 2'b00;
  localparam logic [1:0] OP_WR   = 2'b01;
  localparam logic [1:0] OP_POLL = 2'b10;
  localparam logic [2:0] RD_LAT  = 3'(RD_LATENCY);

  typedef enum logic [2:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP, S_GAP} state_t;

  state_t      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  wait_cnt_q, wait_cnt_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [3:0]  bus_wmask_q, bus_wmask_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic        busy_q, busy_d;
  logic        read_done;
  logic        op_ok;

`ifdef MMIO_POLL_EN
  logic [31:0] mask_q, mask_d;
  logic [15:0] poll_cnt_q, poll_cnt_d;
  logic [15:0] poll_cnt_n;
  logic        poll_match;
`else
  // Poll inputs and limit have no function in this build.
  logic unused_poll;
  assign unused_poll = ^{cmd_i_mask, POLL_MAX};
`endif

  // Next-state, bus and response computation.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wait_cnt_d  = wait_cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    bus_addr_d  = bus_addr_q;
    bus_wmask_d = bus_wmask_q;
    bus_wdata_d = bus_wdata_q;
    read_done   = 1'b0;
`ifdef MMIO_POLL_EN
    mask_d      = mask_q;
    poll_cnt_d  = poll_cnt_q;
    poll_cnt_n  = poll_cnt_q + 16'd1;
    poll_match  = ((mmio_i_rdata ^ wdata_q) & mask_q) == 32'h0;
    op_ok       = (cmd_i_op != 2'b11);
`else
    op_ok       = (cmd_i_op == OP_RD) || (cmd_i_op == OP_WR);
`endif

    case (state_q)
      S_IDLE: begin
        if (cmd_ready_q && cmd_i_valid) begin
          op_d    = cmd_i_op;
          addr_d  = cmd_i_addr;
          wdata_d = cmd_i_wdata;
`ifdef MMIO_POLL_EN
          mask_d     = cmd_i_mask;
          poll_cnt_d = 16'd0;
`endif
          if (op_ok) begin
            state_d     = S_ACCESS;
            bus_addr_d  = cmd_i_addr;
            bus_wmask_d = (cmd_i_op == OP_WR) ? cmd_i_wmask : 4'h0;
            bus_wdata_d = (cmd_i_op == OP_WR) ? cmd_i_wdata : 32'h0;
          end else begin
            // Unsupported op: answer at once, bus stays parked.
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 32'h0;
          end
        end
      end
      S_ACCESS: begin
        if (op_q == OP_WR) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = 32'h0;
          bus_addr_d  = IDLE_ADDR;
          bus_wmask_d = 4'h0;
          bus_wdata_d = 32'h0;
        end else if (RD_LAT == 3'd0) begin
          read_done = 1'b1;
        end else begin
          state_d    = S_WAIT;
          wait_cnt_d = 3'd1;
        end
      end
      S_WAIT: begin
        if (wait_cnt_q == RD_LAT) read_done = 1'b1;
        else wait_cnt_d = wait_cnt_q + 3'd1;
      end
      S_RESP: begin
        if (rsp_i_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      S_GAP: begin
        // Re-launch the poll read after one parked cycle.
        state_d    = S_ACCESS;
        bus_addr_d = addr_q;
      end
      default: state_d = S_IDLE;
    endcase

    // Last cycle of a read: capture data and park the bus.
    if (read_done) begin
      bus_addr_d  = IDLE_ADDR;
      bus_wmask_d = 4'h0;
      bus_wdata_d = 32'h0;
      rsp_rdata_d = mmio_i_rdata;
      rsp_err_d   = 1'b0;
      state_d     = S_RESP;
      rsp_valid_d = 1'b1;
`ifdef MMIO_POLL_EN
      if (op_q == OP_POLL) begin
        poll_cnt_d = poll_cnt_n;
        if (!poll_match) begin
          if (poll_cnt_n == POLL_MAX) begin
            rsp_err_d = 1'b1;
          end else begin
            state_d     = S_GAP;
            rsp_valid_d = 1'b0;
          end
        end
      end
`endif
    end

    cmd_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
  end

  // State and registered outputs; reset drops any in-flight command.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      op_q        <= OP_RD;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      wait_cnt_q  <= 3'd0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
      bus_addr_q  <= IDLE_ADDR;
      bus_wmask_q <= 4'h0;
      bus_wdata_q <= 32'h0;
      busy_q      <= 1'b0;
`ifdef MMIO_POLL_EN
      mask_q      <= 32'h0;
      poll_cnt_q  <= 16'd0;
`endif
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wait_cnt_q  <= wait_cnt_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      bus_addr_q  <= bus_addr_d;
      bus_wmask_q <= bus_wmask_d;
      bus_wdata_q <= bus_wdata_d;
      busy_q      <= busy_d;
`ifdef MMIO_POLL_EN
      mask_q      <= mask_d;
      poll_cnt_q  <= poll_cnt_d;
`endif
    end
  end

  assign cmd_o_ready  = cmd_ready_q;
  assign rsp_o_valid  = rsp_valid_q;
  assign rsp_o_rdata  = rsp_rdata_q;
  assign rsp_o_err    = rsp_err_q;
  assign mmio_o_addr  = bus_addr_q;
  assign mmio_o_wmask = bus_wmask_q;
  assign mmio_o_wdata = bus_wdata_q;
  assign busy         = busy_q;

endmodule
